// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request and result bundle between the datapath controller and seq_alu.
// Instantiate it with the same WIDTH/SHW as the seq_alu it connects to.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
);
  logic             Start;
  logic [3:0]       FS;
  logic [SHW-1:0]   SH;
  logic             CIn;
  logic [WIDTH-1:0] OprdA;
  logic [WIDTH-1:0] OprdB;
  logic [WIDTH-1:0] FOut;
  logic [WIDTH-1:0] FOutHi;
  logic             Busy;
  logic             Done;
  logic             Z;
  logic             C;
  logic             V;
  logic             N;
  logic             D;

  // Controller side: issues operations, reads results.
  modport master (
    output Start, FS, SH, CIn, OprdA, OprdB,
    input  FOut, FOutHi, Busy, Done, Z, C, V, N, D
  );

  // ALU side.
  modport slave (
    input  Start, FS, SH, CIn, OprdA, OprdB,
    output FOut, FOutHi, Busy, Done, Z, C, V, N, D
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with registered result/flags, Start/Busy/Done handshake,
// single-cycle ops 0-13 and iterative unsigned MUL/DIV (one bit per cycle).
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input logic        Clk,
  input logic        Rst_n,
  seq_alu_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'd0,  OpAdc = 4'd1,  OpSub = 4'd2,  OpSbb = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4,  OpOr  = 4'd5,  OpXor = 4'd6,  OpNot = 4'd7;
  localparam logic [3:0] OpInc = 4'd8,  OpDec = 4'd9,  OpShl = 4'd10, OpShr = 4'd11;
  localparam logic [3:0] OpAsr = 4'd12, OpRol = 4'd13, OpMul = 4'd14, OpDiv = 4'd15;

  typedef enum logic [0:0] {StIdle, StIter} state_e;

  state_e           stateQ, stateD;
  logic [CW-1:0]    cntQ, cntD;
  logic [WIDTH-1:0] accHiQ, accHiD, accLoQ, accLoD, opBQ, opBD;
  logic             isDivQ, isDivD;
  logic [WIDTH-1:0] fOutQ, fOutD, fOutHiQ, fOutHiD;
  logic             doneQ, doneD, zQ, zD, cQ, cD, vQ, vD, nQ, nD, dQ, dD;

  logic [WIDTH-1:0]   a, b;
  logic [CW-1:0]      shAmt;
  logic [2*WIDTH-1:0] rolW;
  logic [WIDTH:0]     shrW, asrW, wide;
  logic [WIDTH-1:0]   aluRes;
  logic               aluC, aluV;
  logic [WIDTH:0]     mulSum, remSh, remDiff;
  logic [WIDTH-1:0]   stepHi, stepLo;

  assign a = bus.OprdA;
  assign b = bus.OprdB;

  // Clamp the shift amount and form the shifted operands used by ops 10-13.
  always_comb begin
    shAmt = (32'(bus.SH) >= WIDTH) ? CW'(WIDTH - 1) : CW'(bus.SH);
    // Lower half of {a,a}<<s is SHL, upper half is ROL; bit WIDTH is the last bit out of both.
    rolW  = {a, a} << shAmt;
    // Spare LSB catches the last bit shifted out on right shifts.
    shrW  = {a, 1'b0} >> shAmt;
    asrW  = $unsigned($signed({a, 1'b0}) >>> shAmt);
  end

  // Single-cycle result, carry/borrow and signed overflow.
  always_comb begin
    wide   = '0;
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (bus.FS)
      OpAdd, OpAdc: begin
        wide   = {1'b0, a} + {1'b0, b} + ((bus.FS == OpAdc) ? {{WIDTH{1'b0}}, bus.CIn} : '0);
        aluRes = wide[WIDTH-1:0];
        aluC   = wide[WIDTH];
        aluV   = (a[WIDTH-1] == b[WIDTH-1]) && (aluRes[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub, OpSbb: begin
        wide   = {1'b0, a} - {1'b0, b} - ((bus.FS == OpSbb) ? {{WIDTH{1'b0}}, bus.CIn} : '0);
        aluRes = wide[WIDTH-1:0];
        aluC   = wide[WIDTH];
        aluV   = (a[WIDTH-1] != b[WIDTH-1]) && (aluRes[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: aluRes = a & b;
      OpOr:  aluRes = a | b;
      OpXor: aluRes = a ^ b;
      OpNot: aluRes = ~a;
      OpInc: begin
        wide   = {1'b0, a} + (WIDTH + 1)'(1);
        aluRes = wide[WIDTH-1:0];
        aluC   = wide[WIDTH];
        aluV   = ~a[WIDTH-1] & aluRes[WIDTH-1];
      end
      OpDec: begin
        wide   = {1'b0, a} - (WIDTH + 1)'(1);
        aluRes = wide[WIDTH-1:0];
        aluC   = wide[WIDTH];
        aluV   = a[WIDTH-1] & ~aluRes[WIDTH-1];
      end
      OpShl: begin
        aluRes = rolW[WIDTH-1:0];
        aluC   = (shAmt != '0) & rolW[WIDTH];
      end
      OpShr: begin
        aluRes = shrW[WIDTH:1];
        aluC   = (shAmt != '0) & shrW[0];
      end
      OpAsr: begin
        aluRes = asrW[WIDTH:1];
        aluC   = (shAmt != '0) & asrW[0];
      end
      OpRol: begin
        aluRes = rolW[2*WIDTH-1:WIDTH];
        aluC   = (shAmt != '0) & rolW[WIDTH];
      end
      default: ;
    endcase
  end

  // One MUL shift-add or DIV restoring-subtract step on the accumulator pair.
  always_comb begin
    mulSum  = {1'b0, accHiQ} + (accLoQ[0] ? {1'b0, opBQ} : '0);
    remSh   = {accHiQ, accLoQ[WIDTH-1]};
    remDiff = remSh - {1'b0, opBQ};
    if (isDivQ) begin
      // No borrow means the partial remainder is >= divisor: keep the difference.
      stepHi = remDiff[WIDTH] ? remSh[WIDTH-1:0] : remDiff[WIDTH-1:0];
      stepLo = {accLoQ[WIDTH-2:0], ~remDiff[WIDTH]};
    end else begin
      {stepHi, stepLo} = {mulSum, accLoQ[WIDTH-1:1]};
    end
  end

  // Next-state: issue in IDLE, iterate in ITER, register results with a Done pulse.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    accHiD  = accHiQ;
    accLoD  = accLoQ;
    opBD    = opBQ;
    isDivD  = isDivQ;
    fOutD   = fOutQ;
    fOutHiD = fOutHiQ;
    doneD   = 1'b0;
    zD      = zQ;
    cD      = cQ;
    vD      = vQ;
    nD      = nQ;
    dD      = dQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.Start) begin
          if (bus.FS == OpMul || (bus.FS == OpDiv && b != '0)) begin
            stateD = StIter;
            cntD   = CW'(WIDTH - 1);
            accHiD = '0;
            accLoD = a;
            opBD   = b;
            isDivD = (bus.FS == OpDiv);
          end else if (bus.FS == OpDiv) begin
            fOutD   = '1;
            fOutHiD = a;
            doneD   = 1'b1;
            {zD, cD, vD, nD, dD} = 5'b00001;
          end else begin
            fOutD   = aluRes;
            fOutHiD = '0;
            doneD   = 1'b1;
            zD      = (aluRes == '0);
            cD      = aluC;
            vD      = aluV;
            nD      = aluRes[WIDTH-1];
            dD      = 1'b0;
          end
        end
      end
      StIter: begin
        accHiD = stepHi;
        accLoD = stepLo;
        cntD   = cntQ - 1'b1;
        if (cntQ == '0) begin
          stateD  = StIdle;
          cntD    = '0;
          fOutD   = stepLo;
          fOutHiD = stepHi;
          doneD   = 1'b1;
          vD      = 1'b0;
          dD      = 1'b0;
          if (isDivQ) begin
            zD = (stepLo == '0);
            cD = 1'b0;
            nD = stepLo[WIDTH-1];
          end else begin
            zD = ({stepHi, stepLo} == '0);
            cD = (stepHi != '0);
            nD = stepHi[WIDTH-1];
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State and output registers; reset aborts any in-flight MUL/DIV.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      accHiQ  <= '0;
      accLoQ  <= '0;
      opBQ    <= '0;
      isDivQ  <= 1'b0;
      fOutQ   <= '0;
      fOutHiQ <= '0;
      doneQ   <= 1'b0;
      zQ      <= 1'b0;
      cQ      <= 1'b0;
      vQ      <= 1'b0;
      nQ      <= 1'b0;
      dQ      <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      accHiQ  <= accHiD;
      accLoQ  <= accLoD;
      opBQ    <= opBD;
      isDivQ  <= isDivD;
      fOutQ   <= fOutD;
      fOutHiQ <= fOutHiD;
      doneQ   <= doneD;
      zQ      <= zD;
      cQ      <= cD;
      vQ      <= vD;
      nQ      <= nD;
      dQ      <= dD;
    end
  end

  assign bus.FOut   = fOutQ;
  assign bus.FOutHi = fOutHiQ;
  assign bus.Busy   = (stateQ == StIter);
  assign bus.Done   = doneQ;
  assign bus.Z      = zQ;
  assign bus.C      = cQ;
  assign bus.V      = vQ;
  assign bus.N      = nQ;
  assign bus.D      = dQ;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu; stimulus pushes expectations, a monitor checks each Done.
module tb_seq_alu;

  localparam int W    = 8;
  localparam int SHWP = 3;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W), .SHW(SHWP)) bus ();

  seq_alu #(.WIDTH(W), .SHW(SHWP)) dut (
    .Clk   (clk),
    .Rst_n (rstN),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    int    fOut;
    int    fOutHi;
    int    flags;  // {Z,C,V,N,D}
    int    due;    // edge count after which Done must be seen
  } exp_t;

  exp_t q[$];
  int   cyc  = 0;
  int   nCmp = 0;
  int   nBad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model straight from the opcode table and flag rules.
  function automatic exp_t model(int fs, int a, int b, int sh, int cin);
    exp_t e;
    int r, hi, c, v, z, n, d, s, sa, sb, sres, p;
    hi = 0; c = 0; v = 0; d = 0; sres = 0;
    s  = (sh > W - 1) ? W - 1 : sh;
    sa = (a > SMAX) ? a - (1 << W) : a;
    sb = (b > SMAX) ? b - (1 << W) : b;
    case (fs)
      0: begin r = a + b;       c = (r > MASK) ? 1 : 0; sres = sa + sb; end
      1: begin r = a + b + cin; c = (r > MASK) ? 1 : 0; sres = sa + sb + cin; end
      2: begin r = a - b;       c = (a < b) ? 1 : 0;       sres = sa - sb; end
      3: begin r = a - b - cin; c = (a < b + cin) ? 1 : 0; sres = sa - sb - cin; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~a;
      8: begin r = a + 1; c = (r > MASK) ? 1 : 0; sres = sa + 1; end
      9: begin r = a - 1; c = (a < 1) ? 1 : 0;    sres = sa - 1; end
      10: begin r = a << s; c = (s > 0) ? (a >> (W - s)) & 1 : 0; end
      11: begin r = a >> s; c = (s > 0) ? (a >> (s - 1)) & 1 : 0; end
      12: begin r = sa >>> s; c = (s > 0) ? (a >> (s - 1)) & 1 : 0; end
      13: begin r = (a << s) | (a >> (W - s)); c = (s > 0) ? r & 1 : 0; end
      14: begin p = a * b; r = p; hi = p >> W; c = (hi != 0) ? 1 : 0; end
      default: begin
        if (b == 0) begin r = MASK; hi = a; d = 1; end
        else begin r = a / b; hi = a % b; end
      end
    endcase
    if (fs <= 3 || fs == 8 || fs == 9) v = (sres > SMAX || sres < SMIN) ? 1 : 0;
    r = r & MASK;
    if (fs == 14) begin
      z = (p == 0) ? 1 : 0;
      n = (hi >> (W - 1)) & 1;
    end else if (fs == 15 && b == 0) begin
      z = 0;
      n = 0;
    end else begin
      z = (r == 0) ? 1 : 0;
      n = (r >> (W - 1)) & 1;
    end
    e.tag    = "";
    e.fOut   = r;
    e.fOutHi = hi;
    e.flags  = (z << 4) | (c << 3) | (v << 2) | (n << 1) | d;
    e.due    = 0;
    return e;
  endfunction

  function automatic int lat(int fs, int b);
    return (fs == 14 || (fs == 15 && b != 0)) ? W + 1 : 1;
  endfunction

  // Drive one Start pulse; returns #1 after the sampling edge.
  task automatic drive(input int fs, input int a, input int b, input int sh, input int cin);
    bus.FS    = 4'(fs);
    bus.OprdA = W'(a);
    bus.OprdB = W'(b);
    bus.SH    = SHWP'(sh);
    bus.CIn   = 1'(cin);
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic issueM(input string tag, input int fs, input int a, input int b, input int sh,
                        input int cin);
    exp_t e;
    e     = model(fs, a, b, sh, cin);
    e.tag = tag;
    e.due = cyc + lat(fs, b);
    q.push_back(e);
    drive(fs, a, b, sh, cin);
  endtask

  task automatic issueC(input string tag, input int fs, input int a, input int b, input int sh,
                        input int fOut, input int fOutHi, input int flags);
    exp_t e;
    e.tag    = tag;
    e.fOut   = fOut;
    e.fOutHi = fOutHi;
    e.flags  = flags;
    e.due    = cyc + lat(fs, b);
    q.push_back(e);
    drive(fs, a, b, sh, 0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (bus.Busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.Busy) begin
      nCmp++;
      nBad++;
      $display("FAIL %s busy timeout: Busy still 1 after %0d cycles, expected 0", tag, n);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " FOut"}, int'(bus.FOut), 0);
    chk({tag, " FOutHi"}, int'(bus.FOutHi), 0);
    chk({tag, " Busy"}, int'(bus.Busy), 0);
    chk({tag, " Done"}, int'(bus.Done), 0);
    chk({tag, " flags"}, int'({bus.Z, bus.C, bus.V, bus.N, bus.D}), 0);
  endtask

  // Monitor: every Done must match the oldest outstanding expectation, on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstN && bus.Done) begin
        if (q.size() == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL spurious Done at cycle %0d: got Done=1, expected Done=0", cyc);
        end else begin
          e = q.pop_front();
          chk({e.tag, " FOut"}, int'(bus.FOut), e.fOut);
          chk({e.tag, " FOutHi"}, int'(bus.FOutHi), e.fOutHi);
          chk({e.tag, " flags ZCVND"}, int'({bus.Z, bus.C, bus.V, bus.N, bus.D}), e.flags);
          chk({e.tag, " done cycle"}, cyc, e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs, a, b, sh, cin;
    bus.Start = 1'b0;
    bus.FS    = '0;
    bus.SH    = '0;
    bus.CIn   = 1'b0;
    bus.OprdA = '0;
    bus.OprdB = '0;
    repeat (2) @(posedge clk);
    #1;
    chkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    issueC("add 7A+52", 0, 'h7A, 'h52, 0, 'hCC, 0, 5'b00110);
    issueC("sub 7A-52", 2, 'h7A, 'h52, 0, 'h28, 0, 5'b00000);

    for (int f = 0; f <= 13; f++) issueM($sformatf("sweep fs%0d", f), f, 'h7A, 'h52, 4, 1);

    // MUL with an ignored Start mid-operation and an explicit Busy profile.
    issueC("mul 7A*52", 14, 'h7A, 'h52, 0, 'h14, 'h27, 5'b01000);
    for (int k = 1; k <= W + 1; k++) begin
      if (k == 3) begin
        bus.FS    = 4'd0;
        bus.Start = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("mul Busy k=%0d", k), int'(bus.Busy), (k <= W) ? 1 : 0);
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
    end

    issueC("div 7A/52", 15, 'h7A, 'h52, 0, 'h01, 'h28, 5'b00000);
    waitIdle("div");
    issueC("div 7A/0", 15, 'h7A, 'h00, 0, 'hFF, 'h7A, 5'b00001);
    issueC("add FF+01", 0, 'hFF, 'h01, 0, 'h00, 0, 5'b11000);
    issueC("sub 00-01", 2, 'h00, 'h01, 0, 'hFF, 0, 5'b01010);
    issueC("shl sh0", 10, 'h7A, 'h00, 0, 'h7A, 0, 5'b00000);

    // Reset four cycles into a MUL: outputs clear at once and the MUL never completes.
    drive(14, 'h7A, 'h52, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chkAllZero("abort");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    issueC("add after reset", 0, 'h01, 'h02, 0, 'h03, 0, 5'b00000);
    repeat (12) begin
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 150; i++) begin
      fs  = $urandom_range(0, 15);
      a   = $urandom_range(0, MASK);
      b   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
      sh  = $urandom_range(0, (1 << SHWP) - 1);
      cin = $urandom_range(0, 1);
      issueM($sformatf("rand%0d fs%0d a%0h b%0h sh%0d ci%0d", i, fs, a, b, sh, cin),
             fs, a, b, sh, cin);
      if (lat(fs, b) > 1) waitIdle("rand");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("outstanding expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked multi-cycle ALU for the microprocessor datapath. It keeps the 4-bit FS opcode, SH shift amount and Z/C/V/N/D flag set of the combinational 8-bit ALU, and adds three things: registered outputs with a Start/Busy/Done handshake, carry-in ops, and iterative multiply/divide with a double-width result. The controller issues one operation at a time and reads FOut and the flags when Done pulses.

## Interface
- WIDTH, 8, operand/result width (≥4)
- SHW, 3, SH width; shift range 0..2^SHW-1, clamped to WIDTH-1
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only when Busy=0
- FS  in  4  opcode
- SH  in  SHW  shift/rotate amount
- CIn  in  1  carry/borrow in (ADC, SBB)
- OprdA, OprdB  in  WIDTH  operands, captured at Start
- FOut  out  WIDTH  result low / quotient
- FOutHi  out  WIDTH  MUL high half / DIV remainder; 0 for other ops
- Busy  out  1  multi-cycle op in progress
- Done  out  1  one-cycle pulse: outputs valid
- Z, C, V, N, D  out  1 each  flags, registered with result

## Operation
- Opcodes:
  - 0 ADD, 1 ADC (A+B+CIn), 2 SUB (A-B), 3 SBB (A-B-CIn)
  - 4 AND, 5 OR, 6 XOR, 7 NOT A
  - 8 INC A, 9 DEC A
  - 10 SHL A, 11 SHR (logical), 12 ASR, 13 ROL A by SH
  - 14 MUL (unsigned), 15 DIV (unsigned)
- FSM states: IDLE, ITER.
  - IDLE + Start with FS 0–13: compute, register outputs, Done=1; stay in IDLE.
  - IDLE + Start with FS 14/15 and B≠0 (or MUL): latch operands, load counter = WIDTH-1, Busy=1, go to ITER.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. At counter = 0: register result, Done=1, Busy=0, go to IDLE.
- DIV with B=0: completes in 1 cycle from IDLE. FOut = all ones, FOutHi = A, D=1, other flags 0.
- Flags:
  - Z: result == 0. For MUL, Z covers the full {FOutHi,FOut}.
  - N: MSB of FOut. For MUL, MSB of FOutHi.
  - C: carry-out for add ops. Borrow for SUB/SBB/DEC (1 when A < subtrahend, unsigned). Last bit shifted out for shifts/rotate; 0 when SH=0. For MUL, C = (FOutHi ≠ 0). Otherwise 0.
  - V: signed overflow for ops 0–3, 8, 9; otherwise 0.
  - D: 1 only for DIV by zero.
- Outputs hold between Done pulses. Operand or FS changes while Busy have no effect.

## Timing
- Reset (asynchronous, any state): FOut=0, FOutHi=0, Busy=0, Done=0, all flags 0, FSM→IDLE, counter=0. An in-flight MUL/DIV is aborted and discarded. The first Start is accepted on the first rising edge after Rst_n deasserts.
- Single-cycle ops: Start sampled at edge t. Result, flags and Done=1 are valid after edge t. Done falls after t+1 unless a new Start arrives.
- MUL/DIV: Start at edge t. Busy=1 after edge t. Result, Done=1 and Busy=0 appear after edge t+WIDTH. Latency is WIDTH cycles (8 at default).
- Start while Busy=1 is ignored: no queueing, no error.
- Back-to-back issue: Start is legal in the same cycle Done=1, since Busy=0. Single-cycle ops sustain one result per clock.
- Shift amount SH ≥ WIDTH is treated as WIDTH-1.

## Test plan
- Reset, then ADD with A=7A, B=52 → after 1 edge: FOut=CC, Done=1, V=1, N=1, C=0, Z=0. SUB on the next clock → FOut=28, C=0, V=0.
- Sweep FS 0–13 back-to-back, one Start per clock, with A=7A, B=52, SH=4, CIn=1. Check one Done per clock. Spot values: ADC=CD, SHL=A0 with C=1, ROL=A7, NOT=85, DEC=79.
- MUL with A=7A, B=52: Busy for 8 cycles, then FOutHi=27, FOut=14, C=1, Done=1. A Start pulsed mid-operation is ignored.
- DIV with A=7A, B=52: after 8 cycles FOut=01, FOutHi=28. DIV with B=00: after 1 cycle FOut=FF, FOutHi=7A, D=1.
- Assert Rst_n=0 four cycles into a MUL: all outputs go to 0 immediately and no Done follows. A new ADD issued after release completes normally.
- Boundary checks: ADD FF+01 → FOut=00, Z=1, C=1. SUB 00-01 → FF, C=1, N=1. SH=0 shift → FOut=A, C=0.
